// File: rtl/wb_bus_arbiter_pkg.sv
// Shared writeback-bus definitions for the execute stage and the ROB.
// Packet layout: [38] valid, [37:32] rd (physical register), [31:0] result.
package wb_bus_arbiter_pkg;

  localparam int unsigned WB_NUM_REQ   = 4;   // ALU0, ALU1, ALU2, LSU
  localparam int unsigned WB_NUM_BUS   = 3;   // bus0..bus2
  localparam int unsigned BUS_WIDTH    = 39;
  localparam int unsigned WB_Q_DEPTH   = 2;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rd;
    logic [31:0] result;
  } wb_pkt_t;

endpackage

// File: rtl/wb_queue.sv
// Small per-requester result FIFO.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous clear (overrides push and pop)
//   push/push_data  enqueue at tail (ignored when full)
//   pop             dequeue head (ignored when empty)
//   head_data       current head entry (valid only when !empty)
//   count/full/empty occupancy status, all from registered state
module wb_queue #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 39,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Writeback bus arbiter: queues results from NUM_REQ functional units and
// grants up to three queue heads per cycle, round-robin, onto registered buses.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        synchronous clear of all queued results and buses
//   req_valid    per-requester result valid
//   req_pkt      per-requester packet, requester i at [i*BUS_W +: BUS_W]
//   req_ready    per-requester queue has room (0 while in reset)
//   bus0..bus2   registered writeback packets, valid bit at MSB
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = WB_NUM_REQ,
  parameter int unsigned NUM_BUS = WB_NUM_BUS,
  parameter int unsigned BUS_W   = BUS_WIDTH,
  parameter int unsigned Q_DEPTH = WB_Q_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*BUS_W-1:0] req_pkt,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [BUS_W-1:0]         bus0,
  output logic [BUS_W-1:0]         bus1,
  output logic [BUS_W-1:0]         bus2
);

  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
  localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BUS_W-1:0] VALID_BIT = BUS_W'(1) << (BUS_W - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(Q_DEPTH);

  logic [BUS_W-1:0]   q_head  [NUM_REQ];
  logic [CNT_W-1:0]   q_count [NUM_REQ];
  logic [NUM_REQ-1:0] q_full, q_empty, q_push, grant;

  logic [BUS_W-1:0]   bus_q [NUM_BUS];
  logic [BUS_W-1:0]   bus_d [NUM_BUS];
  logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [RR_W-1:0]    idx, last_idx;
  int unsigned        n_granted;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_q
    assign req_ready[g] = (q_count[g] < DEPTH_CNT) && rst_n;
    assign q_push[g]    = req_valid[g] && !q_full[g];

    wb_queue #(
      .DEPTH (Q_DEPTH),
      .WIDTH (BUS_W)
    ) u_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (q_push[g]),
      .push_data (req_pkt[g*BUS_W +: BUS_W]),
      .pop       (grant[g]),
      .head_data (q_head[g]),
      .count     (q_count[g]),
      .full      (q_full[g]),
      .empty     (q_empty[g])
    );
  end

  // Scan from rr_ptr; the n-th non-empty queue found lands on bus n.
  always_comb begin
    grant     = '0;
    bus_d     = '{default: '0};
    rr_ptr_d  = rr_ptr_q;
    idx       = '0;
    last_idx  = '0;
    n_granted = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = RR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!q_empty[idx] && (n_granted < NUM_BUS)) begin
        grant[idx] = 1'b1;
        for (int unsigned b = 0; b < NUM_BUS; b++) begin
          if (b == n_granted) begin
            bus_d[b] = q_head[idx] | VALID_BIT;
          end
        end
        last_idx  = idx;
        n_granted = n_granted + 1;
      end
    end
    if (n_granted != 0) begin
      rr_ptr_d = RR_W'((32'(last_idx) + 1) % NUM_REQ);
    end
    if (flush) begin
      grant    = '0;
      bus_d    = '{default: '0};
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q    <= '{default: '0};
      rr_ptr_q <= '0;
    end else begin
      bus_q    <= bus_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus0 = bus_q[0];
  assign bus1 = bus_q[1];
  assign bus2 = bus_q[2];

endmodule
